llr_chan_buffer: RTL and testbench

- Channel-side input stage of the SC polar decoder, directly upstream of the f/g LLR processing element.
- Accepts quantized channel LLRs serially over a valid/ready handshake and saturates them to DATA_WIDTH.
- Stores each N-LLR frame in a ping-pong double buffer, so frame k+1 loads while frame k is decoded.
- Presents stage-0 operand pairs a = LLR[i], b = LLR[i+N/2] to the PE's a/b inputs, with one-cycle read latency.

---
 rtl/llr_chan_buffer_if.sv | 32 +++
 rtl/llr_chan_buffer.sv | 123 ++++++++++++
 tb/tb_llr_chan_buffer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/llr_chan_buffer_if.sv
// Bundles the channel-LLR write stream, the PE pair-read port and the frame
// control/status signals of llr_chan_buffer into a single interface.
interface llr_chan_buffer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int IN_WIDTH   = 12,
   parameter int N          = 8
);
   localparam int PW = (N > 2) ? $clog2(N / 2) : 1;

   logic                         in_valid;
   logic signed [IN_WIDTH-1:0]   in_data;
   logic                         in_last;
   logic                         in_ready;
   logic                         frame_rdy;
   logic                         rd_en;
   logic [PW-1:0]                rd_pair_addr;
   logic signed [DATA_WIDTH-1:0] a_out;
   logic signed [DATA_WIDTH-1:0] b_out;
   logic                         rd_valid;
   logic                         frame_done;
   logic                         frame_err;

   modport slave (
      input  in_valid, in_data, in_last, rd_en, rd_pair_addr, frame_done,
      output in_ready, frame_rdy, a_out, b_out, rd_valid, frame_err
   );

   modport master (
      output in_valid, in_data, in_last, rd_en, rd_pair_addr, frame_done,
      input  in_ready, frame_rdy, a_out, b_out, rd_valid, frame_err
   );
endinterface

// File: rtl/llr_chan_buffer.sv
// Channel-side input stage of the SC polar decoder: saturates serial channel
// LLRs into a ping-pong frame buffer and serves stage-0 (a, b) pairs to the PE.
module llr_chan_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int IN_WIDTH   = 12,
   parameter int N          = 8
) (
   input  logic             clk,
   input  logic             rst,
   llr_chan_buffer_if.slave bus
);
   localparam int AW   = $clog2(N);
   localparam int HALF = N / 2;
   localparam logic signed [IN_WIDTH-1:0] SAT_MAX  = IN_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
   localparam logic signed [IN_WIDTH-1:0] SAT_MIN  = -SAT_MAX;
   localparam logic [AW-1:0]              LAST_IDX = AW'(N - 1);

   logic signed [DATA_WIDTH-1:0] mem [2][N];

   logic                         wr_bank;
   logic                         rd_bank;
   logic [AW-1:0]                wr_cnt;
   logic [1:0]                   bank_full;
   logic [1:0]                   bank_full_nxt;
   logic signed [DATA_WIDTH-1:0] a_q;
   logic signed [DATA_WIDTH-1:0] b_q;
   logic                         rd_valid_q;
   logic                         frame_err_q;

   logic                         in_ready_w;
   logic                         frame_rdy_w;
   logic                         wr_fire;
   logic                         at_end;
   logic                         rd_fire;
   logic                         rel_fire;
   logic [AW-1:0]                addr_a;
   logic [AW-1:0]                addr_b;
   logic signed [DATA_WIDTH-1:0] sat_data;

   assign in_ready_w  = ~bank_full[wr_bank];
   assign frame_rdy_w = bank_full[rd_bank];
   assign wr_fire     = bus.in_valid & in_ready_w;
   assign at_end      = (wr_cnt == LAST_IDX);
   assign rd_fire     = bus.rd_en & frame_rdy_w;
   assign rel_fire    = bus.frame_done & frame_rdy_w;
   assign addr_a      = AW'(bus.rd_pair_addr);
   assign addr_b      = addr_a + AW'(HALF);

   assign bus.in_ready  = in_ready_w;
   assign bus.frame_rdy = frame_rdy_w;
   assign bus.a_out     = a_q;
   assign bus.b_out     = b_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.frame_err = frame_err_q;

   // Symmetric clamp so the PE can always negate an operand without overflow.
   always_comb begin
      sat_data = bus.in_data[DATA_WIDTH-1:0];
      if (bus.in_data > SAT_MAX) begin
         sat_data = SAT_MAX[DATA_WIDTH-1:0];
      end else if (bus.in_data < SAT_MIN) begin
         sat_data = SAT_MIN[DATA_WIDTH-1:0];
      end
   end

   // Commit and release can never hit the same bank in one cycle, so both apply.
   always_comb begin
      bank_full_nxt = bank_full;
      if (wr_fire && at_end) begin
         bank_full_nxt[wr_bank] = 1'b1;
      end
      if (rel_fire) begin
         bank_full_nxt[rd_bank] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_bank][wr_cnt] <= sat_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         wr_cnt      <= '0;
         bank_full   <= 2'b00;
         a_q         <= '0;
         b_q         <= '0;
         rd_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         bank_full   <= bank_full_nxt;
         rd_valid_q  <= rd_fire;
         frame_err_q <= 1'b0;

         // A full count always commits; a short frame ending in in_last is dropped.
         if (wr_fire) begin
            if (at_end) begin
               wr_bank     <= ~wr_bank;
               wr_cnt      <= '0;
               frame_err_q <= ~bus.in_last;
            end else if (bus.in_last) begin
               wr_cnt      <= '0;
               frame_err_q <= 1'b1;
            end else begin
               wr_cnt      <= wr_cnt + AW'(1);
            end
         end

         // The read uses the pre-toggle rd_bank when it coincides with a release.
         if (rd_fire) begin
            a_q <= mem[rd_bank][addr_a];
            b_q <= mem[rd_bank][addr_b];
         end

         if (rel_fire) begin
            rd_bank <= ~rd_bank;
         end
      end
   end
endmodule

// File: tb/tb_llr_chan_buffer.sv
// Scoreboard bench for llr_chan_buffer: reads push expected pairs, a negedge
// monitor pops them whenever rd_valid is seen and also tallies frame_err pulses.
module tb_llr_chan_buffer;
   localparam int DW = 8;
   localparam int IW = 12;
   localparam int NN = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks     = 0;
   int failures   = 0;
   int err_pulses = 0;
   int exp_a[$];
   int exp_b[$];
   int mon_a;
   int mon_b;

   int frame_a[8] = '{5, -3, 200, -300, 0, 127, -128, 1};
   int frame_b[8] = '{10, 20, 30, 40, 50, 60, 70, 80};
   int frame_c[8] = '{-1, -2, -3, -4, -5, -6, -7, -8};
   int frame_d[8] = '{100, -100, 255, -255, 7, 8, 9, 2047};
   int frame_e[8] = '{3, -3, 64, -64, 11, -11, 126, -126};

   llr_chan_buffer_if #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .N(NN)) bus ();

   llr_chan_buffer #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .N(NN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Monitor: every rd_valid must match the oldest outstanding expected pair.
   always @(negedge clk) begin
      if (bus.frame_err) err_pulses++;
      if (bus.rd_valid) begin
         if (exp_a.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_rd_valid actual=1 expected=0");
         end else begin
            mon_a = exp_a.pop_front();
            mon_b = exp_b.pop_front();
            check_output("pair_a", int'(bus.a_out), mon_a);
            check_output("pair_b", int'(bus.b_out), mon_b);
         end
      end
   end

   task automatic send_beat(input int data, input bit last);
      bus.in_valid = 1'b1;
      bus.in_data  = IW'(data);
      bus.in_last  = last;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic apply_stimulus(input int d[8], input int last_beat);
      for (int k = 0; k < 8; k++) send_beat(d[k], k == last_beat);
   endtask

   task automatic read_pair(input int i, input int ea, input int eb);
      bus.rd_en        = 1'b1;
      bus.rd_pair_addr = 2'(i);
      exp_a.push_back(ea);
      exp_b.push_back(eb);
      @(posedge clk); #1;
      bus.rd_en = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_a.size() != 0 && n < 8) begin
         @(negedge clk); #1;
         n++;
      end
      check_output("drain_queue", exp_a.size(), 0);
   endtask

   task automatic release_frame();
      bus.frame_done = 1'b1;
      @(posedge clk); #1;
      bus.frame_done = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.in_valid     = 1'b0;
      bus.in_data      = '0;
      bus.in_last      = 1'b0;
      bus.rd_en        = 1'b0;
      bus.rd_pair_addr = '0;
      bus.frame_done   = 1'b0;

      repeat (3) @(posedge clk); #1;
      check_output("rst_in_ready", int'(bus.in_ready), 1);
      check_output("rst_frame_rdy", int'(bus.frame_rdy), 0);
      check_output("rst_rd_valid", int'(bus.rd_valid), 0);
      check_output("rst_a_out", int'(bus.a_out), 0);
      check_output("rst_b_out", int'(bus.b_out), 0);
      check_output("rst_frame_err", int'(bus.frame_err), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic frame with saturation, then back-to-back pair reads.
      apply_stimulus(frame_a, 7);
      check_output("a_frame_rdy", int'(bus.frame_rdy), 1);
      check_output("a_in_ready", int'(bus.in_ready), 1);
      read_pair(0, 5, 0);
      read_pair(1, -3, 127);
      read_pair(2, 127, -127);
      read_pair(3, -127, 1);
      drain();
      @(posedge clk); #1;
      check_output("idle_rd_valid", int'(bus.rd_valid), 0);
      check_output("a_err_count", err_pulses, 0);

      // Both banks full: backpressure, held beat, then release with a final read.
      apply_stimulus(frame_b, 7);
      check_output("full_in_ready", int'(bus.in_ready), 0);
      check_output("full_frame_rdy", int'(bus.frame_rdy), 1);
      bus.in_valid = 1'b1;
      bus.in_data  = IW'(99);
      bus.in_last  = 1'b1;
      repeat (2) @(posedge clk); #1;
      check_output("held_in_ready", int'(bus.in_ready), 0);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      @(posedge clk); #1;
      check_output("held_err_count", err_pulses, 0);
      read_pair(0, 5, 0);
      drain();
      bus.rd_en        = 1'b1;
      bus.rd_pair_addr = 2'(3);
      bus.frame_done   = 1'b1;
      exp_a.push_back(-127);
      exp_b.push_back(1);
      @(posedge clk); #1;
      bus.rd_en      = 1'b0;
      bus.frame_done = 1'b0;
      check_output("rel_in_ready", int'(bus.in_ready), 1);
      check_output("rel_frame_rdy", int'(bus.frame_rdy), 1);
      drain();
      read_pair(0, 10, 50);
      read_pair(1, 20, 60);
      read_pair(2, 30, 70);
      read_pair(3, 40, 80);
      drain();
      release_frame();
      check_output("empty_frame_rdy", int'(bus.frame_rdy), 0);
      check_output("empty_in_ready", int'(bus.in_ready), 1);

      // Reads and releases with no frame available are ignored.
      bus.rd_en        = 1'b1;
      bus.rd_pair_addr = 2'(1);
      @(posedge clk); #1;
      bus.rd_en = 1'b0;
      @(negedge clk);
      check_output("noframe_rd_valid", int'(bus.rd_valid), 0);
      check_output("noframe_a_hold", int'(bus.a_out), 40);
      check_output("noframe_b_hold", int'(bus.b_out), 80);
      @(posedge clk); #1;
      release_frame();

      // Early in_last aborts the partial frame; the next full frame is clean.
      for (int k = 0; k < 4; k++) send_beat(k + 1, k == 3);
      check_output("early_frame_rdy", int'(bus.frame_rdy), 0);
      @(posedge clk); #1;
      check_output("early_err_count", err_pulses, 1);
      apply_stimulus(frame_c, 7);
      check_output("c_frame_rdy", int'(bus.frame_rdy), 1);
      read_pair(0, -1, -5);
      read_pair(1, -2, -6);
      read_pair(3, -4, -8);
      drain();
      check_output("c_err_count", err_pulses, 1);
      release_frame();

      // Missing in_last on the final beat still commits the frame.
      apply_stimulus(frame_d, -1);
      check_output("d_frame_rdy", int'(bus.frame_rdy), 1);
      @(posedge clk); #1;
      check_output("d_err_count", err_pulses, 2);
      read_pair(2, 127, 9);
      read_pair(3, -127, 127);
      read_pair(0, 100, 7);
      drain();

      // Reset mid-frame with one bank full discards everything.
      for (int k = 0; k < 5; k++) send_beat(50 + k, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      check_output("mrst_in_ready", int'(bus.in_ready), 1);
      check_output("mrst_frame_rdy", int'(bus.frame_rdy), 0);
      check_output("mrst_a_out", int'(bus.a_out), 0);
      check_output("mrst_b_out", int'(bus.b_out), 0);
      check_output("mrst_frame_err", int'(bus.frame_err), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      apply_stimulus(frame_e, 7);
      check_output("e_frame_rdy", int'(bus.frame_rdy), 1);
      read_pair(0, 3, 11);
      read_pair(1, -3, -11);
      read_pair(2, 64, 126);
      read_pair(3, -64, -126);
      drain();
      @(posedge clk); #1;
      check_output("e_err_count", err_pulses, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
